// File: rtl/dj8_pkg.sv
// Shared definitions for the banked DJ8 register file: default sizes, reset value,
// copy-engine states and register-pair index helpers.
package dj8_pkg;

  localparam int unsigned DefaultDw       = 8;
  localparam int unsigned DefaultNregs    = 8;
  localparam logic [7:0]  DefaultResetVal = 8'h80;

  typedef enum logic {StIdle, StCopy} copy_state_e;

  // Pair p is {reg[2p], reg[2p+1]}: even register holds the high byte.
  function automatic int unsigned pair_hi_idx(input int unsigned p);
    return 2 * p;
  endfunction

  function automatic int unsigned pair_lo_idx(input int unsigned p);
    return 2 * p + 1;
  endfunction

endpackage

// File: rtl/dj8_regbank.sv
// One bank of NREGS x DW registers with a per-register write enable and a flat output.
module dj8_regbank
  import dj8_pkg::*;
#(
  parameter int unsigned    DW        = DefaultDw,
  parameter int unsigned    NREGS     = DefaultNregs,
  parameter logic [DW-1:0]  RESET_VAL = DW'(DefaultResetVal)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NREGS-1:0]    we_i,
  input  logic [NREGS*DW-1:0] wd_i,
  output logic [NREGS*DW-1:0] regs_o
);

  logic [NREGS*DW-1:0] regs_q;

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        regs_q[i*DW +: DW] <= RESET_VAL;
      end else if (we_i[i]) begin
        regs_q[i*DW +: DW] <= wd_i[i*DW +: DW];
      end
    end
  end

  assign regs_o = regs_q;

endmodule

// File: rtl/dj8_regfile_banked.sv
// Dual-bank DJ8 register file: bank select, write arbitration, pair arithmetic and
// the active-to-shadow copy engine with write-through.
module dj8_regfile_banked
  import dj8_pkg::*;
#(
  parameter int unsigned   DW        = DefaultDw,
  parameter int unsigned   NREGS     = DefaultNregs,
  parameter logic [DW-1:0] RESET_VAL = DW'(DefaultResetVal),
  localparam int unsigned  AW        = $clog2(NREGS),
  localparam int unsigned  NPAIRS    = NREGS / 2,
  localparam int unsigned  PW        = $clog2(NPAIRS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [AW-1:0]            ra_addr,
  input  logic [AW-1:0]            rb_addr,
  output logic [DW-1:0]            ra_data,
  output logic [DW-1:0]            rb_data,
  input  logic                     we,
  input  logic [AW-1:0]            wa,
  input  logic [DW-1:0]            wd,
  input  logic [PW-1:0]            pair_sel,
  input  logic                     pair_we,
  input  logic [2*DW-1:0]          pair_wd,
  input  logic                     pair_inc,
  input  logic                     pair_dec,
  input  logic                     swap_req,
  input  logic                     copy_req,
  output logic [DW-1:0]            acc,
  output logic [NPAIRS*2*DW-1:0]   pairs,
  output logic                     bank,
  output logic                     busy,
  output logic                     done
);

  logic [NREGS*DW-1:0] bank0_regs, bank1_regs, wd_flat;
  logic [NREGS-1:0]    bank0_we, bank1_we, act_we, shd_we, copy_onehot;
  logic [DW-1:0]       act    [NREGS];
  logic [DW-1:0]       act_wd [NREGS];

  logic                bank_q, bank_d, done_q, done_d;
  copy_state_e         state_q, state_d;
  logic [AW-1:0]       k_q, k_d;

  logic [AW-1:0]       hi_idx, lo_idx;
  logic [2*DW-1:0]     pair_cur, pair_res;
  logic                pair_arith;

  for (genvar i = 0; i < NREGS; i++) begin : g_unpack
    assign act[i]                 = bank_q ? bank1_regs[i*DW +: DW] : bank0_regs[i*DW +: DW];
    assign wd_flat[i*DW +: DW]    = act_wd[i];
  end

  for (genvar p = 0; p < NPAIRS; p++) begin : g_pairs
    assign pairs[p*2*DW +: 2*DW] = {act[2*p], act[2*p+1]};
  end

  assign hi_idx     = AW'(pair_hi_idx(32'(pair_sel)));
  assign lo_idx     = AW'(pair_lo_idx(32'(pair_sel)));
  assign pair_cur   = {act[hi_idx], act[lo_idx]};
  assign pair_arith = pair_inc ^ pair_dec;
  assign pair_res   = pair_inc ? pair_cur + (2*DW)'(1) : pair_cur - (2*DW)'(1);

  // Later assignments override earlier ones: arithmetic > pair load > byte write.
  always_comb begin
    act_we = '0;
    act_wd = act;
    if (we) begin
      act_we[wa] = 1'b1;
      act_wd[wa] = wd;
    end
    if (pair_we) begin
      act_we[hi_idx] = 1'b1;
      act_we[lo_idx] = 1'b1;
      act_wd[hi_idx] = pair_wd[2*DW-1:DW];
      act_wd[lo_idx] = pair_wd[DW-1:0];
    end
    if (pair_arith) begin
      act_we[hi_idx] = 1'b1;
      act_we[lo_idx] = 1'b1;
      act_wd[hi_idx] = pair_res[2*DW-1:DW];
      act_wd[lo_idx] = pair_res[DW-1:0];
    end
  end

  // Both banks share one data bus: unwritten entries carry the current active value,
  // so the copy slot and any write-through land correctly with write-through winning.
  assign copy_onehot = {{(NREGS-1){1'b0}}, 1'b1} << k_q;
  assign shd_we      = (state_q == StCopy) ? (act_we | copy_onehot) : '0;
  assign bank0_we    = bank_q ? shd_we : act_we;
  assign bank1_we    = bank_q ? act_we : shd_we;

  dj8_regbank #(
    .DW        (DW),
    .NREGS     (NREGS),
    .RESET_VAL (RESET_VAL)
  ) u_bank0 (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .we_i   (bank0_we),
    .wd_i   (wd_flat),
    .regs_o (bank0_regs)
  );

  dj8_regbank #(
    .DW        (DW),
    .NREGS     (NREGS),
    .RESET_VAL (RESET_VAL)
  ) u_bank1 (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .we_i   (bank1_we),
    .wd_i   (wd_flat),
    .regs_o (bank1_regs)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    bank_d  = bank_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (swap_req) begin
          bank_d = ~bank_q;
        end else if (copy_req) begin
          state_d = StCopy;
          k_d     = '0;
        end
      end
      StCopy: begin
        k_d = k_q + AW'(1);
        if (k_q == AW'(NREGS - 1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      bank_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      bank_q  <= bank_d;
      done_q  <= done_d;
    end
  end

  assign ra_data = act[ra_addr];
  assign rb_data = act[rb_addr];
  assign acc     = act[0];
  assign bank    = bank_q;
  assign busy    = (state_q == StCopy);
  assign done    = done_q;

endmodule

// File: tb/tb_dj8_regfile_banked.sv
// Directed plus randomized bench for dj8_regfile_banked against a two-bank array model.
module tb_dj8_regfile_banked;

  localparam int unsigned DW     = 8;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned AW     = 3;
  localparam int unsigned NPAIRS = 4;
  localparam int unsigned PW     = 2;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [AW-1:0]          ra_addr, rb_addr, wa;
  logic [DW-1:0]          ra_data, rb_data, wd, acc;
  logic                   we, pair_we, pair_inc, pair_dec, swap_req, copy_req;
  logic [PW-1:0]          pair_sel;
  logic [2*DW-1:0]        pair_wd;
  logic [NPAIRS*2*DW-1:0] pairs;
  logic                   bank, busy, done;

  int checks   = 0;
  int failures = 0;

  // Reference: two register arrays, which one is active, and copy progress.
  int unsigned mreg [2][NREGS];
  int unsigned msel, mk;
  bit          mbusy, mdone;

  dj8_regfile_banked dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ra_addr  (ra_addr),
    .rb_addr  (rb_addr),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .pair_sel (pair_sel),
    .pair_we  (pair_we),
    .pair_wd  (pair_wd),
    .pair_inc (pair_inc),
    .pair_dec (pair_dec),
    .swap_req (swap_req),
    .copy_req (copy_req),
    .acc      (acc),
    .pairs    (pairs),
    .bank     (bank),
    .busy     (busy),
    .done     (done)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < NREGS; i++) mreg[b][i] = 32'h80;
    end
    msel  = 0;
    mk    = 0;
    mbusy = 1'b0;
    mdone = 1'b0;
  endtask

  task automatic model_edge();
    int unsigned nxt [NREGS];
    bit          wr  [NREGS];
    int unsigned a, p, v;
    a = msel;
    p = 32'(pair_sel);
    for (int i = 0; i < NREGS; i++) begin
      nxt[i] = mreg[a][i];
      wr[i]  = 1'b0;
    end
    if (we) begin
      nxt[wa] = 32'(wd);
      wr[wa]  = 1'b1;
    end
    if (pair_we) begin
      nxt[2*p]   = 32'(pair_wd[15:8]);
      nxt[2*p+1] = 32'(pair_wd[7:0]);
      wr[2*p]    = 1'b1;
      wr[2*p+1]  = 1'b1;
    end
    if (pair_inc != pair_dec) begin
      v = mreg[a][2*p] * 256 + mreg[a][2*p+1];
      v = pair_inc ? (v + 1) % 65536 : (v + 65535) % 65536;
      nxt[2*p]   = v / 256;
      nxt[2*p+1] = v % 256;
      wr[2*p]    = 1'b1;
      wr[2*p+1]  = 1'b1;
    end
    mdone = 1'b0;
    if (mbusy) begin
      mreg[1-a][mk] = mreg[a][mk];
      for (int i = 0; i < NREGS; i++) if (wr[i]) mreg[1-a][i] = nxt[i];
      mk++;
      if (mk == NREGS) begin
        mbusy = 1'b0;
        mdone = 1'b1;
      end
    end else if (swap_req) begin
      msel = 1 - a;
    end else if (copy_req) begin
      mbusy = 1'b1;
      mk    = 0;
    end
    for (int i = 0; i < NREGS; i++) mreg[a][i] = nxt[i];
  endtask

  task automatic check_all();
    check("bank", 32'(bank), msel);
    check("busy", 32'(busy), 32'(mbusy));
    check("done", 32'(done), 32'(mdone));
    check("acc", 32'(acc), mreg[msel][0]);
    for (int p = 0; p < NPAIRS; p++) begin
      check($sformatf("pair%0d", p), 32'(pairs[p*16 +: 16]),
            mreg[msel][2*p] * 256 + mreg[msel][2*p+1]);
    end
    for (int i = 0; i < NREGS; i++) begin
      ra_addr = AW'(i);
      rb_addr = AW'(NREGS - 1 - i);
      #1;
      check($sformatf("ra_data[%0d]", i), 32'(ra_data), mreg[msel][i]);
      check($sformatf("rb_data[%0d]", NREGS - 1 - i), 32'(rb_data), mreg[msel][NREGS-1-i]);
    end
  endtask

  task automatic idle_inputs();
    we       = 1'b0;
    wa       = '0;
    wd       = '0;
    pair_sel = '0;
    pair_we  = 1'b0;
    pair_wd  = '0;
    pair_inc = 1'b0;
    pair_dec = 1'b0;
    swap_req = 1'b0;
    copy_req = 1'b0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    idle_inputs();
  endtask

  initial begin
    int busy_cycles;
    bit saw_done;

    reset_n = 1'b0;
    ra_addr = '0;
    rb_addr = '0;
    idle_inputs();
    model_reset();
    #30;
    check_all();
    reset_n = 1'b1;

    // Pair wrap in both directions.
    pair_sel = 2'd2; pair_we = 1'b1; pair_wd = 16'hFFFF;
    step();
    pair_sel = 2'd2; pair_inc = 1'b1;
    step();
    check("pair2_inc_wrap", 32'(pairs[32 +: 16]), 32'h0000);
    pair_sel = 2'd2; pair_dec = 1'b1;
    step();
    check("pair2_dec_wrap", 32'(pairs[32 +: 16]), 32'hFFFF);

    // Arithmetic beats a byte write to the same register.
    pair_sel = 2'd2; pair_we = 1'b1; pair_wd = 16'h8080;
    step();
    we = 1'b1; wa = 3'd4; wd = 8'h11; pair_sel = 2'd2; pair_inc = 1'b1;
    step();
    ra_addr = 3'd4; #1;
    check("arith_over_byte_reg4", 32'(ra_data), 32'h80);
    ra_addr = 3'd5; #1;
    check("arith_over_byte_reg5", 32'(ra_data), 32'h81);

    // inc and dec together: no arithmetic, the load still applies.
    pair_sel = 2'd1; pair_inc = 1'b1; pair_dec = 1'b1; pair_we = 1'b1; pair_wd = 16'h1234;
    step();
    check("inc_dec_cancel_load", 32'(pairs[16 +: 16]), 32'h1234);

    // Bank swap hides and restores reg0.
    we = 1'b1; wa = 3'd0; wd = 8'h5A;
    step();
    swap_req = 1'b1;
    step();
    check("swap1_acc", 32'(acc), 32'h80);
    check("swap1_bank", 32'(bank), 32'h1);
    swap_req = 1'b1;
    step();
    check("swap2_acc", 32'(acc), 32'h5A);

    // swap and copy together in idle: swap wins.
    swap_req = 1'b1; copy_req = 1'b1;
    step();
    check("swap_beats_copy_busy", 32'(busy), 32'h0);
    swap_req = 1'b1;
    step();

    // Copy with a write-through to an already-copied register and an ignored swap.
    copy_req = 1'b1;
    step();
    busy_cycles = 0;
    saw_done    = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (busy !== 1'b1) break;
      busy_cycles++;
      if (busy_cycles == 3) begin
        we = 1'b1; wa = 3'd1; wd = 8'h33;
      end
      if (busy_cycles == 5) swap_req = 1'b1;
      step();
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("copy_busy_cycles", 32'(busy_cycles), 32'd8);
    check("copy_done_seen", 32'(saw_done), 32'h1);
    swap_req = 1'b1;
    step();
    ra_addr = 3'd1; #1;
    check("shadow_reg1_write_through", 32'(ra_data), 32'h33);

    // Reset in the fourth busy cycle aborts the copy.
    copy_req = 1'b1;
    step();
    step();
    step();
    step();
    reset_n = 1'b0;
    #1;
    model_reset();
    check("reset_abort_busy", 32'(busy), 32'h0);
    check_all();
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("reset_abort_no_done", 32'(saw_done), 32'h0);
    swap_req = 1'b1;
    step();

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      we       = 1'($urandom_range(0, 1));
      wa       = AW'($urandom);
      wd       = DW'($urandom);
      pair_sel = PW'($urandom);
      pair_we  = ($urandom_range(0, 3) == 0);
      pair_wd  = 16'($urandom);
      pair_inc = ($urandom_range(0, 3) == 0);
      pair_dec = ($urandom_range(0, 3) == 0);
      swap_req = ($urandom_range(0, 9) == 0);
      copy_req = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dj8_regfile_banked.md
# dj8_regfile_banked

Parametrised, dual-bank successor to the DJ8 register file. It provides two asynchronous read ports, one byte write port, and a register-pair port with 16-bit load and post-increment/decrement for pointer pairs. It adds a shadow bank that can be swapped in one cycle for interrupt entry/exit, plus a background copy engine that snapshots the active bank into the shadow bank. It sits between the DJ8 decoder/ALU and the address generator, which consumes the pair outputs.

## Interface
- DW, 8, register width in bits
- NREGS, 8, registers per bank; power of two, ≥4; AW = log2(NREGS), NPAIRS = NREGS/2, PW = log2(NPAIRS)
- RESET_VAL, 8'h80, reset value of every register in both banks
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ra_addr, rb_addr  in  AW  read addresses
- ra_data, rb_data  out  DW  combinational read of active bank
- we  in  1  byte write enable
- wa  in  AW  byte write address
- wd  in  DW  byte write data
- pair_sel  in  PW  pair p = {reg[2p] high, reg[2p+1] low}
- pair_we  in  1  load pair_wd into selected pair
- pair_wd  in  2*DW  pair load data
- pair_inc, pair_dec  in  1  post-increment / post-decrement selected pair
- swap_req  in  1  toggle active bank
- copy_req  in  1  start active→shadow copy
- acc  out  DW  active reg[0]
- pairs  out  NPAIRS*2*DW  all active pairs, pair p at bits [p*2DW +: 2DW]
- bank  out  1  index of active bank
- busy  out  1  copy in progress
- done  out  1  one-cycle pulse at copy completion

## Operation
- Reset: all registers in both banks = RESET_VAL, bank=0, busy=0, done=0; copy pointer = 0.
- Reads are combinational from the active bank. There is no write bypass: a write is visible after the edge.
- Per-edge update of the active bank, in priority order on overlapping registers: pair_inc/pair_dec > pair_we > we. Non-overlapping targets all update in the same cycle.
- pair_inc and pair_dec asserted together: no arithmetic, and pair_we/we still apply.
- Pair arithmetic is modulo 2^(2*DW): {FF,FF}+1 → {00,00}, and {00,00}−1 → {FF,FF}.
- swap_req while idle: bank toggles at the edge. Writes in the same cycle land in the pre-swap bank.
- swap_req while busy is ignored.
- copy_req while idle (and swap_req low): FSM IDLE→COPY, busy=1 from the next cycle, pointer k=0.
- COPY: each cycle shadow[k] ← active[k], k++. After the cycle with k = NREGS−1, the FSM goes to IDLE, busy=0 and done=1 for one cycle.
- copy_req while busy is ignored. When swap_req and copy_req arrive together in idle, swap wins and copy is dropped.
- Write-through during COPY: every active-bank write (byte, pair load, or pair arithmetic result) is also written to the same index in the shadow bank.
- If a write-through and the copy engine hit the same shadow index in one cycle, the write-through wins. At completion the shadow equals the active bank exactly.
- reset_n assertion mid-copy aborts the copy immediately and applies full reset values.

## Timing
- Read latency 0 (combinational). Write latency 1 edge.
- Copy occupies exactly NREGS cycles. done is high in the first cycle after the last copy cycle, coincident with busy falling.
- bank, busy, done, acc and pairs are registered or derived directly from registered state. No combinational path from inputs to bank, busy or done.

## Structure
- Shared package dj8_pkg: DW/NREGS defaults, RESET_VAL, the copy FSM state enum (IDLE, COPY), and a pair-index helper function.
- One sub-module, dj8_regbank: a single bank of NREGS×DW with one write port and a flat output. It is instantiated twice.
- The top level holds the bank select, the write arbitration, the pair incrementer/decrementer and the copy FSM.

## Test plan
- Reset → all ra_data reads return 8'h80, acc=8'h80, pairs all 16'h8080, bank=0, busy=0.
- pair_sel=2, pair_we, pair_wd=16'hFFFF, then pair_inc → pair2 = 16'h0000; then pair_dec → 16'hFFFF.
- Same cycle: we to wa=4 with wd=8'h11, plus pair_inc on pair_sel=2 = {80,80} → reg4 = 8'h80, reg5 = 8'h81 (arithmetic wins).
- Load reg0=8'h5A, swap_req → acc=8'h80, bank=1. swap_req again → acc=8'h5A.
- copy_req; in the 3rd busy cycle write reg1=8'h33 (already copied) → busy for 8 cycles, done pulse. After swap, reg1 reads 8'h33 and all other registers match the source bank.
- reset_n low during cycle 4 of a copy → busy=0, done never pulses, both banks read 8'h80.
